// File: rtl/pulse_sequencer.sv
// Pulse sequencer: turns a rising edge on fire_pulse into a burst of
// num_pulses injection pulses. Each pulse is followed by a bx_delay wait,
// a one-cycle check_strobe, and a restore_cnt settle gap. Burst settings
// are latched when the request is accepted, so later input changes only
// affect the next burst.
module pulse_sequencer #(
    parameter int CNT_W = 12,
    parameter int RST_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             fire_pulse,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [3:0]       pulse_width,
    input  logic [3:0]       bx_delay,
    input  logic [RST_W-1:0] restore_cnt,
    output logic             pulse_out,
    output logic             check_strobe,
    output logic             pulser_ready,
    output logic [CNT_W-1:0] pulses_sent
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PULSE   = 3'd1;
    localparam logic [2:0] S_DELAY   = 3'd2;
    localparam logic [2:0] S_CHECK   = 3'd3;
    localparam logic [2:0] S_RESTORE = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_n;
    logic [RST_W-1:0] cnt;
    logic [RST_W-1:0] cnt_n;
    logic             fire_d;
    logic             start;
    logic             accept;
    logic [3:0]       w_eff;
    logic [3:0]       w_lat;
    logic [3:0]       d_lat;
    logic [RST_W-1:0] r_lat;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] sent_inc;

    // A request is a rising edge; only accepted while idle with a non-zero count.
    assign start    = fire_pulse & ~fire_d;
    assign accept   = start && (state == S_IDLE) && (num_pulses != '0);
    assign w_eff    = (pulse_width == 4'd0) ? 4'd1 : pulse_width;
    assign sent_inc = pulses_sent + CNT_W'(1);

    // Next-state and phase-counter logic; cnt holds remaining cycles minus one.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_n = S_PULSE;
                    cnt_n   = RST_W'(w_eff) - RST_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    if (d_lat != 4'd0) begin
                        state_n = S_DELAY;
                        cnt_n   = RST_W'(d_lat) - RST_W'(1);
                    end else begin
                        state_n = S_CHECK;
                    end
                end else begin
                    cnt_n = cnt - RST_W'(1);
                end
            end
            S_DELAY: begin
                if (cnt == '0) begin
                    state_n = S_CHECK;
                end else begin
                    cnt_n = cnt - RST_W'(1);
                end
            end
            S_CHECK: begin
                // pulses_sent is bumped on this same edge, so look one ahead.
                if (r_lat != '0) begin
                    state_n = S_RESTORE;
                    cnt_n   = r_lat - RST_W'(1);
                end else if (sent_inc < n_lat) begin
                    state_n = S_PULSE;
                    cnt_n   = RST_W'(w_lat) - RST_W'(1);
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_RESTORE: begin
                if (cnt == '0) begin
                    if (pulses_sent < n_lat) begin
                        state_n = S_PULSE;
                        cnt_n   = RST_W'(w_lat) - RST_W'(1);
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt - RST_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, edge-detect history and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            fire_d       <= 1'b1;
            pulse_out    <= 1'b0;
            check_strobe <= 1'b0;
            pulser_ready <= 1'b1;
            pulses_sent  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            fire_d       <= fire_pulse;
            pulse_out    <= (state_n == S_PULSE);
            check_strobe <= (state_n == S_CHECK);
            pulser_ready <= (state_n == S_IDLE);
            if (accept) begin
                pulses_sent <= '0;
            end else if ((state == S_CHECK) && (pulses_sent != n_lat)) begin
                pulses_sent <= sent_inc;
            end
        end
    end

    // Burst settings captured at acceptance; untouched for the rest of the burst.
    always_ff @(posedge clock) begin
        if (accept) begin
            w_lat <= w_eff;
            d_lat <= bx_delay;
            r_lat <= restore_cnt;
            n_lat <= num_pulses;
        end
    end

endmodule
